// File: rtl/rx_frame_ctrl_if.sv
// Receive-side bundle between the XGMII receive port, the frame controller
// and the rx field-extraction stage.
//   master : drives rxd64/rxc8, observes everything the controller produces
//   slave  : the frame controller (consumes rxd64/rxc8, drives the rest)
interface rx_frame_ctrl_if;
  logic [63:0] rxd64;       // XGMII data, lane 7 first on the wire
  logic [7:0]  rxc8;        // XGMII control flag per lane
  logic [63:0] rxd64_d1;    // rxd64 one cycle late
  logic [63:0] rxd64_d2;    // rxd64 two cycles late
  logic        start_da;    // rxd64_d1 holds post-SFD word 1
  logic        start_lt;    // rxd64_d1 holds post-SFD word 2
  logic        receiving;   // frame in progress
  logic        frame_done;  // one-cycle end-of-frame strobe
  logic [15:0] frame_len;   // DA..FCS byte count of last frame
  logic        too_short;   // last frame below minimum length
  logic        too_long;    // last frame above maximum length
  logic        code_err;    // last frame aborted on a control error

  modport master (
    output rxd64, rxc8,
    input  rxd64_d1, rxd64_d2, start_da, start_lt, receiving,
           frame_done, frame_len, too_short, too_long, code_err
  );

  modport slave (
    input  rxd64, rxc8,
    output rxd64_d1, rxd64_d2, start_da, start_lt, receiving,
           frame_done, frame_len, too_short, too_long, code_err
  );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: finds start-of-frame on a 64-bit XGMII stream,
// tracks frame position, counts DA..FCS bytes and reports one status per
// frame. Also feeds the field stage its delayed data copies and strobes.
// Ports:
//   rxclk  : receive clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : rx_frame_ctrl_if.slave (XGMII in, pipeline/strobes/status out)
module rx_frame_ctrl #(
  parameter int unsigned MAX_FRAME = 1518,
  parameter int unsigned MIN_FRAME = 64
) (
  input logic           rxclk,
  input logic           reset,
  rx_frame_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_FRAME);
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_FRAME);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DA,
    S_LT,
    S_DATA,
    S_DROP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    cnt_sum;
  logic [63:0]       rxd64_d1_q, rxd64_d2_q;
  logic              start_da_q, start_lt_q, receiving_q, frame_done_q;
  logic [CNT_W-1:0]  frame_len_q;
  logic              too_short_q, too_long_q, code_err_q;

  logic              sof_c, term_found_c, ctrl_above_c;
  logic              clean_term_c, ctrl_err_c, drop_end_c;
  logic [2:0]        term_lane_c;
  logic [3:0]        tail_bytes_c;
  logic              cnt_clr_c, eof_c, abort_c;
  logic [3:0]        add_c;

  // Classify the input word: SOF, terminator lane and control errors.
  always_comb begin
    sof_c        = (bus.rxc8 == 8'h80) && (bus.rxd64[63:56] == 8'hFB) &&
                   (bus.rxd64[7:0] == 8'hAB);
    term_found_c = 1'b0;
    term_lane_c  = 3'd0;
    ctrl_above_c = 1'b0;
    // Scan in wire order; any control lane before the first FD is an error.
    for (int i = 7; i >= 0; i--) begin
      if (!term_found_c && bus.rxc8[i]) begin
        if (bus.rxd64[8*i +: 8] == 8'hFD) begin
          term_found_c = 1'b1;
          term_lane_c  = 3'(i);
        end else begin
          ctrl_above_c = 1'b1;
        end
      end
    end
    clean_term_c = term_found_c && !ctrl_above_c;
    ctrl_err_c   = term_found_c ? ctrl_above_c : (|bus.rxc8);
    // term_found_c is also "FD present in some control lane".
    drop_end_c   = term_found_c || (bus.rxc8 == 8'hFF);
    tail_bytes_c = 4'(3'd7 - term_lane_c);
  end

  // State register.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (sof_c) state_d = S_DA;
      S_DA: begin
        if      (clean_term_c) state_d = S_IDLE;
        else if (ctrl_err_c)   state_d = S_DROP;
        else                   state_d = S_LT;
      end
      S_LT: begin
        if      (clean_term_c) state_d = S_IDLE;
        else if (ctrl_err_c)   state_d = S_DROP;
        else                   state_d = S_DATA;
      end
      S_DATA: begin
        if      (clean_term_c) state_d = S_IDLE;
        else if (ctrl_err_c)   state_d = S_DROP;
      end
      S_DROP: if (drop_end_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state counter and end-of-frame decisions.
  always_comb begin
    cnt_clr_c = 1'b0;
    add_c     = 4'd0;
    eof_c     = 1'b0;
    abort_c   = 1'b0;
    case (state_q)
      S_IDLE: cnt_clr_c = sof_c;
      S_DA, S_LT, S_DATA: begin
        if (clean_term_c) begin
          add_c = tail_bytes_c;
          eof_c = 1'b1;
        end else if (!ctrl_err_c) begin
          add_c = 4'd8;
        end
      end
      S_DROP: begin
        if (drop_end_c) begin
          eof_c   = 1'b1;
          abort_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Saturating byte counter; the final word's bytes are included in cnt_d.
  always_comb begin
    cnt_sum = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(add_c);
    if (cnt_clr_c)       cnt_d = '0;
    else if (cnt_sum[CNT_W]) cnt_d = '1;
    else                 cnt_d = cnt_sum[CNT_W-1:0];
  end

  // Counter, data pipeline, strobes and held frame status.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      rxd64_d1_q   <= '0;
      rxd64_d2_q   <= '0;
      start_da_q   <= 1'b0;
      start_lt_q   <= 1'b0;
      receiving_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      too_short_q  <= 1'b0;
      too_long_q   <= 1'b0;
      code_err_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rxd64_d1_q   <= bus.rxd64;
      rxd64_d2_q   <= rxd64_d1_q;
      start_da_q   <= (state_q == S_DA);
      start_lt_q   <= (state_q == S_LT);
      receiving_q  <= (state_d != S_IDLE);
      frame_done_q <= eof_c;
      if (eof_c) begin
        frame_len_q <= cnt_d;
        too_short_q <= (cnt_d < MIN_LEN);
        too_long_q  <= (cnt_d > MAX_LEN);
        code_err_q  <= abort_c;
      end
    end
  end

  assign bus.rxd64_d1   = rxd64_d1_q;
  assign bus.rxd64_d2   = rxd64_d2_q;
  assign bus.start_da   = start_da_q;
  assign bus.start_lt   = start_lt_q;
  assign bus.receiving  = receiving_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_len  = frame_len_q;
  assign bus.too_short  = too_short_q;
  assign bus.too_long   = too_long_q;
  assign bus.code_err   = code_err_q;

endmodule
